// File: rtl/pll_lock_supervisor_if.sv
// Signals between the PLL lock supervisor, the PLL and the PLL-domain logic it resets.
// The supervisor takes the master modport and the PLL/downstream side takes the slave modport.
interface pll_lock_supervisor_if #(
  parameter int RETRY_W = 4
);
  logic               PLL_LOCKED;
  logic               PLL_RSTN;
  logic               sys_rstn;
  logic               ready;
  logic [RETRY_W-1:0] retry_count;
  logic               lock_lost;
  logic               fault;

  modport master (
    input  PLL_LOCKED,
    output PLL_RSTN, sys_rstn, ready, retry_count, lock_lost, fault
  );

  modport slave (
    output PLL_LOCKED,
    input  PLL_RSTN, sys_rstn, ready, retry_count, lock_lost, fault
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL_RSTN, qualifies a synchronised PLL_LOCKED and releases sys_rstn once lock is stable.
// Optional macro LOCK_RETRY_LIMIT_EN adds a sticky FAULT state after MAX_RETRIES failed attempts.
module pll_lock_supervisor #(
  parameter int RST_CYCLES    = 3_334,
  parameter int LOCK_TIMEOUT  = 333_333,
  parameter int STABLE_CYCLES = 33_333,
  parameter int MAX_RETRIES   = 7,
  parameter int RETRY_W       = 4
) (
  input  logic                    clock,
  input  logic                    rstn,
  pll_lock_supervisor_if.master   pll
);

  localparam int MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CYC = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  if (MAX_RETRIES < 1) begin : g_max_retries_chk
    $error("MAX_RETRIES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_PLL_RESET,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN
`ifdef LOCK_RETRY_LIMIT_EN
    , S_FAULT
`endif
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [RETRY_W-1:0] retry_q, retry_nxt, retry_inc;
  logic               lost_q, lost_nxt;
  logic               pll_rstn_q, sys_rstn_q;
  logic               sync_p0, sync_p1;
  logic               lk;

  // Stage p0/p1: two-flop synchroniser for the asynchronous lock indicator
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= pll.PLL_LOCKED;
      sync_p1 <= sync_p0;
    end
  end

  assign lk        = sync_p1;
  assign retry_inc = (&retry_q) ? retry_q : retry_q + 1'b1;

  always_comb begin
    state_nxt = state;
    retry_nxt = retry_q;
    lost_nxt  = lost_q;
    case (state)
      S_PLL_RESET: begin
        if (cnt == CNT_W'(RST_CYCLES - 1)) state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // Lock seen on the timeout cycle still counts as lock
        if (lk) begin
          state_nxt = S_STABLE;
        end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          retry_nxt = retry_inc;
`ifdef LOCK_RETRY_LIMIT_EN
          if (retry_inc == RETRY_W'(MAX_RETRIES)) state_nxt = S_FAULT;
          else                                    state_nxt = S_PLL_RESET;
`else
          state_nxt = S_PLL_RESET;
`endif
        end
      end
      S_STABLE: begin
        if (!lk)                                     state_nxt = S_WAIT_LOCK;
        else if (cnt == CNT_W'(STABLE_CYCLES - 1))   state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!lk) begin
          state_nxt = S_PLL_RESET;
          lost_nxt  = 1'b1;
        end
      end
`ifdef LOCK_RETRY_LIMIT_EN
      S_FAULT: state_nxt = S_FAULT;
`endif
      default: state_nxt = S_PLL_RESET;
    endcase
  end

  // Outputs are registered from the next state so they move on the same edge as the state
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state      <= S_PLL_RESET;
      cnt        <= '0;
      retry_q    <= '0;
      lost_q     <= 1'b0;
      pll_rstn_q <= 1'b0;
      sys_rstn_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      retry_q    <= retry_nxt;
      lost_q     <= lost_nxt;
      pll_rstn_q <= (state_nxt == S_WAIT_LOCK) || (state_nxt == S_STABLE) || (state_nxt == S_RUN);
      sys_rstn_q <= (state_nxt == S_RUN);
      if (state_nxt != state)      cnt <= '0;
      else if (cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
    end
  end

`ifdef LOCK_RETRY_LIMIT_EN
  logic fault_q;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) fault_q <= 1'b0;
    else       fault_q <= (state_nxt == S_FAULT);
  end

  assign pll.fault = fault_q;
`else
  assign pll.fault = 1'b0;
`endif

  assign pll.PLL_RSTN    = pll_rstn_q;
  assign pll.sys_rstn    = sys_rstn_q;
  assign pll.ready       = sys_rstn_q;
  assign pll.retry_count = retry_q;
  assign pll.lock_lost   = lost_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: expected output edges are queued with their cycle and
// compared as the monitor sees them; status outputs are checked at fixed points.
module tb_pll_lock_supervisor;
  localparam int RETRY_W = 4;
  localparam int P_RISE = 0, P_FALL = 1, S_RISE = 2, S_FALL = 3;

  logic clock = 1'b0;
  logic rstn  = 1'b0;

  pll_lock_supervisor_if #(.RETRY_W(RETRY_W)) pll_if ();

  pll_lock_supervisor #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(10), .STABLE_CYCLES(5), .MAX_RETRIES(2), .RETRY_W(RETRY_W)
  ) dut (
    .clock (clock),
    .rstn  (rstn),
    .pll   (pll_if)
  );

  always #5 clock = ~clock;

  typedef struct { int kind; int at; } ev_t;
  typedef struct { int delay; int srise; int pfall; int retry; } vec_t;

  ev_t  expq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  logic prev_p, prev_s;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    expq.push_back(e);
  endtask

  task automatic got_ev(input int kind);
    ev_t e;
    tests++;
    if (expq.size() == 0) begin
      fails++;
      $display("FAIL event: kind %0d at cycle %0d, expected no event", kind, cyc);
    end else begin
      e = expq.pop_front();
      if (e.kind != kind || e.at != cyc) begin
        fails++;
        $display("FAIL event: kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                 kind, cyc, e.kind, e.at);
      end
    end
  endtask

  // One clock: sample on the falling edge and report output edges to the scoreboard
  task automatic step();
    @(negedge clock);
    cyc++;
    if (pll_if.PLL_RSTN !== prev_p) got_ev(pll_if.PLL_RSTN ? P_RISE : P_FALL);
    if (pll_if.sys_rstn !== prev_s) got_ev(pll_if.sys_rstn ? S_RISE : S_FALL);
    prev_p = pll_if.PLL_RSTN;
    prev_s = pll_if.sys_rstn;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (expq.size() > 0 && n < budget) begin
      step();
      n++;
    end
    tests++;
    if (expq.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d events pending after %0d cycles, expected 0", expq.size(), budget);
      expq.delete();
    end
  endtask

  // Assert rstn between edges and check every output reacts before the next clock edge
  task automatic do_reset(input string where);
    @(negedge clock);
    #2 rstn = 1'b0;
    #1;
    chk({where, " PLL_RSTN"},    int'(pll_if.PLL_RSTN),    0);
    chk({where, " sys_rstn"},    int'(pll_if.sys_rstn),    0);
    chk({where, " ready"},       int'(pll_if.ready),       0);
    chk({where, " retry_count"}, int'(pll_if.retry_count), 0);
    chk({where, " lock_lost"},   int'(pll_if.lock_lost),   0);
    chk({where, " fault"},       int'(pll_if.fault),       0);
    pll_if.PLL_LOCKED = 1'b0;
    expq.delete();
    repeat (2) @(negedge clock);
    rstn   = 1'b1;
    prev_p = pll_if.PLL_RSTN;
    prev_s = pll_if.sys_rstn;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   r;
    int   d;
    int   t;

    // delay: clocks after PLL_RSTN rises before PLL_LOCKED rises.
    // Lock reaches the FSM 3 edges after it changes (2 sync flops + registered decision),
    // then STABLE needs 5 more edges; delay 7 lands on the timeout cycle and lock wins,
    // delay 8 misses it: timeout at +10, PLL_RESET for 4, then 1+5 clocks to RUN.
    vecs[0] = '{delay: 0, srise: 8,  pfall: -1, retry: 0};
    vecs[1] = '{delay: 3, srise: 11, pfall: -1, retry: 0};
    vecs[2] = '{delay: 7, srise: 15, pfall: -1, retry: 0};
    vecs[3] = '{delay: 8, srise: 20, pfall: 10, retry: 1};

    pll_if.PLL_LOCKED = 1'b0;
    do_reset("init");

    foreach (vecs[i]) begin
      do_reset($sformatf("vec%0d", i));
      r = cyc + 4;
      expect_ev(P_RISE, r);
      drain(20);
      repeat (vecs[i].delay) step();
      pll_if.PLL_LOCKED = 1'b1;
      if (vecs[i].pfall >= 0) begin
        expect_ev(P_FALL, r + vecs[i].pfall);
        expect_ev(P_RISE, r + vecs[i].pfall + 4);
      end
      expect_ev(S_RISE, r + vecs[i].srise);
      drain(40);
      chk($sformatf("vec%0d retry_count", i), int'(pll_if.retry_count), vecs[i].retry);
      chk($sformatf("vec%0d ready", i),       int'(pll_if.ready),       1);
      chk($sformatf("vec%0d lock_lost", i),   int'(pll_if.lock_lost),   0);
      chk($sformatf("vec%0d fault", i),       int'(pll_if.fault),       0);
    end

    // Lock drops so that lk falls on the very cycle STABLE would complete; full window again after
    do_reset("run");
    r = cyc + 4;
    expect_ev(P_RISE, r);
    drain(20);
    pll_if.PLL_LOCKED = 1'b1;
    repeat (5) step();
    pll_if.PLL_LOCKED = 1'b0;
    repeat (3) step();
    pll_if.PLL_LOCKED = 1'b1;
    expect_ev(S_RISE, r + 16);
    drain(30);
    chk("glitch lock_lost", int'(pll_if.lock_lost), 0);

    // One-clock lock drop while in RUN
    d = cyc;
    pll_if.PLL_LOCKED = 1'b0;
    step();
    pll_if.PLL_LOCKED = 1'b1;
    expect_ev(P_FALL, d + 3);
    expect_ev(S_FALL, d + 3);
    drain(10);
    chk("loss lock_lost", int'(pll_if.lock_lost), 1);
    chk("loss ready",     int'(pll_if.ready),     0);
    expect_ev(P_RISE, d + 7);
    expect_ev(S_RISE, d + 13);
    drain(20);
    chk("relock lock_lost",   int'(pll_if.lock_lost),   1);
    chk("relock ready",       int'(pll_if.ready),       1);
    chk("relock retry_count", int'(pll_if.retry_count), 0);

    // Reach STABLE, then reset from there
    do_reset("run_lost");
    pll_if.PLL_LOCKED = 1'b1;
    r = cyc + 4;
    expect_ev(P_RISE, r);
    drain(20);
    repeat (2) step();
    chk("stable PLL_RSTN", int'(pll_if.PLL_RSTN), 1);
    do_reset("stable");

    // PLL never locks
    t = cyc + 4;
    expect_ev(P_RISE, t);
    drain(20);
`ifdef LOCK_RETRY_LIMIT_EN
    expect_ev(P_FALL, t + 10);
    drain(20);
    chk("retry1 retry_count", int'(pll_if.retry_count), 1);
    chk("retry1 fault",       int'(pll_if.fault),       0);
    expect_ev(P_RISE, t + 14);
    expect_ev(P_FALL, t + 24);
    drain(30);
    chk("limit fault",       int'(pll_if.fault),       1);
    chk("limit retry_count", int'(pll_if.retry_count), 2);
    repeat (30) step();
    chk("fault hold PLL_RSTN", int'(pll_if.PLL_RSTN), 0);
    chk("fault hold fault",    int'(pll_if.fault),    1);
    do_reset("fault");
`else
    for (int k = 1; k <= 17; k++) begin
      t += 10;
      expect_ev(P_FALL, t);
      drain(20);
      chk($sformatf("timeout%0d retry_count", k), int'(pll_if.retry_count), (k > 15) ? 15 : k);
      chk($sformatf("timeout%0d fault", k),       int'(pll_if.fault),       0);
      t += 4;
      expect_ev(P_RISE, t);
      drain(10);
    end
    do_reset("wait_lock");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
